demux32_buf4: RTL

DEMUX32_BUF4 -- requirements
Module: demux32_buf4

---
 rtl/demux32_buf4.sv | 90 +++++++++
 1 files changed

// File: rtl/demux32_buf4.sv
// demux32_buf4: routes one input word per cycle to one of four output lanes.
// Each lane is an independent FIFO of DEPTH entries, and each lane has its own
// valid/ready handshake.
// A full lane blocks only the words that are addressed to it. A pop on a lane
// never frees space for a push in the same cycle.
module demux32_buf4 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In,
  input  logic             InValid,
  input  logic [1:0]       sel,
  output logic             InReady,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [3:0]       OutValid,
  input  logic [3:0]       OutReady,
  output logic             Busy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] head [4];
  logic [3:0]       full;
  logic [3:0]       push;

  // Input readiness looks only at the addressed lane's registered fill level.
  assign InReady = ~full[sel];

  // Decode an accepted word into a one-hot write strobe for its lane.
  always_comb begin
    push = '0;
    if (InValid && InReady) begin
      push[sel] = 1'b1;
    end
  end

  genvar g;
  for (g = 0; g < 4; g++) begin : g_lane
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop;

    assign pop         = OutReady[g] && (count != '0);
    assign OutValid[g] = (count != '0);
    assign full[g]     = (count == (AW+1)'(DEPTH));
    assign head[g]     = mem[rd_ptr];

    // Lane pointers and occupancy; the pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push[g], pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end

    // Lane storage has no reset; a slot is only read after it has been written.
    always_ff @(posedge Clk) begin
      if (push[g]) begin
        mem[wr_ptr] <= In;
      end
    end
  end

  assign Out0 = head[0];
  assign Out1 = head[1];
  assign Out2 = head[2];
  assign Out3 = head[3];
  assign Busy = |OutValid;

endmodule
